// File: rtl/lfsr_crc_pkg.sv
// Shared states, default widths and helpers for the
// LFSR CRC frame controller.
package lfsr_crc_pkg;

  localparam int DATA_WIDTH_D = 8;
  localparam int CRC_WIDTH_D  = 8;
  localparam int TIMEOUT_D    = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_INIT    = 3'd1;
  localparam state_t ST_SHIFT   = 3'd2;
  localparam state_t ST_WAIT    = 3'd3;
  localparam state_t ST_CAPTURE = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/lfsr_crc_frame_ctrl_capture.sv
// LSB-first serial-to-parallel CRC register.
// word_next already includes the bit arriving this cycle.
module crc_bit_capture
  import lfsr_crc_pkg::*;
#(
  parameter int WIDTH = CRC_WIDTH_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_next,
  output logic             complete
);

  localparam int CW = clog2(WIDTH + 1);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  // merge the incoming bit at position cnt
  always_comb begin
    word_next = sreg;
    if (load)
      word_next = sreg | (WIDTH'(bit_in) << cnt);
  end

  assign complete = load && (cnt == CW'(WIDTH - 1));

  // shift register and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (clear) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= word_next;
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lfsr_crc_frame_ctrl.sv
// Frame controller around the serial LFSR CRC engine.
// Optional expected-CRC compare: LFSR_CRC_CHECK_EN.
module lfsr_crc_frame_ctrl
  import lfsr_crc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int CRC_WIDTH  = CRC_WIDTH_D,
  parameter int TIMEOUT    = TIMEOUT_D
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] In_Data,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  output logic                  Eng_RST,
  output logic                  Data,
  output logic                  Active,
  input  logic                  CRC,
  input  logic                  Valid,
  output logic [CRC_WIDTH-1:0]  CRC_Out,
  output logic                  Out_Valid,
  output logic                  Err
`ifdef LFSR_CRC_CHECK_EN
  ,
  input  logic [CRC_WIDTH-1:0]  In_Exp,
  output logic                  Match
`endif
);

  localparam int SW = clog2(DATA_WIDTH + 1);
  localparam int TW = clog2(TIMEOUT + 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] word;
  logic [SW-1:0]         scnt;
  logic [TW-1:0]         tcnt;
  logic                  in_rx;
  logic                  cap_load;
  logic                  cap_done;
  logic [CRC_WIDTH-1:0]  cap_word;
`ifdef LFSR_CRC_CHECK_EN
  logic [CRC_WIDTH-1:0]  exp_crc;
`endif

  assign In_Ready = (state == ST_IDLE);
  assign in_rx    = (state == ST_WAIT) ||
                    (state == ST_CAPTURE);
  assign cap_load = in_rx && Valid;

  crc_bit_capture #(
    .WIDTH(CRC_WIDTH)
  ) u_cap (
    .clk      (CLK),
    .rst_n    (RST),
    .clear    (!in_rx),
    .load     (cap_load),
    .bit_in   (CRC),
    .word_next(cap_word),
    .complete (cap_done)
  );

  // frame sequencing, serialisation and publishing
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      word      <= '0;
      scnt      <= '0;
      tcnt      <= '0;
      Eng_RST   <= 1'b1;
      Data      <= 1'b0;
      Active    <= 1'b0;
      CRC_Out   <= '0;
      Out_Valid <= 1'b0;
      Err       <= 1'b0;
`ifdef LFSR_CRC_CHECK_EN
      exp_crc   <= '0;
      Match     <= 1'b0;
`endif
    end else begin
      Out_Valid <= 1'b0;
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (In_Valid) begin
            word    <= In_Data;
            Err     <= 1'b0;
            Eng_RST <= 1'b0;
            state   <= ST_INIT;
`ifdef LFSR_CRC_CHECK_EN
            exp_crc <= In_Exp;
            Match   <= 1'b0;
`endif
          end
        end
        (state == ST_INIT): begin
          Eng_RST <= 1'b1;
          Active  <= 1'b1;
          Data    <= word[0];
          word    <= word >> 1;
          scnt    <= SW'(1);
          state   <= ST_SHIFT;
        end
        (state == ST_SHIFT): begin
          if (Valid) begin
            Err    <= 1'b1;
            Active <= 1'b0;
            Data   <= 1'b0;
            state  <= ST_IDLE;
          end else if (scnt == SW'(DATA_WIDTH)) begin
            Active <= 1'b0;
            Data   <= 1'b0;
            tcnt   <= '0;
            state  <= ST_WAIT;
          end else begin
            Data <= word[0];
            word <= word >> 1;
            scnt <= scnt + SW'(1);
          end
        end
        (state == ST_WAIT): begin
          if (Valid) begin
            state <= ST_CAPTURE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            Err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        (state == ST_CAPTURE): begin
          if (!Valid) begin
            Err   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        (state == ST_DONE): begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (cap_done) begin
        CRC_Out   <= cap_word;
        Out_Valid <= 1'b1;
        state     <= ST_DONE;
`ifdef LFSR_CRC_CHECK_EN
        Match     <= (cap_word == exp_crc);
`endif
      end
    end
  end

endmodule

// File: tb/tb_lfsr_crc_frame_ctrl.sv
// Self-checking bench for lfsr_crc_frame_ctrl.
// Sample n is the cycle after the (n-1)th edge past accept.
module tb_lfsr_crc_frame_ctrl;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] In_Data = '0;
  logic          In_Valid = 1'b0;
  logic          In_Ready;
  logic          Eng_RST;
  logic          Data;
  logic          Active;
  logic          CRC = 1'b0;
  logic          Valid = 1'b0;
  logic [CW-1:0] CRC_Out;
  logic          Out_Valid;
  logic          Err;
`ifdef LFSR_CRC_CHECK_EN
  logic [CW-1:0] In_Exp = '0;
  logic          Match;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [CW-1:0] exp_crc_out = '0;

  always #5 CLK = ~CLK;

  lfsr_crc_frame_ctrl #(
    .DATA_WIDTH(DW),
    .CRC_WIDTH (CW),
    .TIMEOUT   (TO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .In_Data  (In_Data),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .Eng_RST  (Eng_RST),
    .Data     (Data),
    .Active   (Active),
    .CRC      (CRC),
    .Valid    (Valid),
    .CRC_Out  (CRC_Out),
    .Out_Valid(Out_Valid),
    .Err      (Err)
`ifdef LFSR_CRC_CHECK_EN
    ,
    .In_Exp   (In_Exp),
    .Match    (Match)
`endif
  );

  typedef struct {
    logic [DW-1:0] word;
    logic [CW-1:0] crc;
    logic [CW-1:0] exp;
    int            vstart;
    int            vlen;
    int            end_n;
    bit            ok;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int n,
                       input logic [31:0] act,
                       input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s n=%0d got=%h want=%h",
               name, n, act, want);
    end
  endtask

  // Outcome of a frame from the protocol rules:
  // serial window is samples 2..DW+1, Active low from
  // DW+2, timeout TO cycles later, CRC takes CW samples.
  function automatic void model(input int vs, input int vl,
                                output int end_n,
                                output bit ok);
    ok = 1'b0;
    if (vl > 0 && vs <= DW + 1)
      end_n = vs + 1;
    else if (vl == 0 || vs > DW + 1 + TO)
      end_n = DW + 2 + TO;
    else if (vl >= CW) begin
      ok = 1'b1;
      end_n = vs + CW;
    end else
      end_n = vs + vl + 1;
  endfunction

  task automatic run_frame(input string name, input vec_t v);
    int act_last;
    act_last = (v.end_n - 1 < DW + 1) ? v.end_n - 1 : DW + 1;
    In_Data  = v.word;
    In_Valid = 1'b1;
    Valid    = 1'b0;
`ifdef LFSR_CRC_CHECK_EN
    In_Exp   = v.exp;
`endif
    @(posedge CLK);
    @(negedge CLK);
    In_Valid = 1'b0;
    for (int n = 1; n <= v.end_n + 1; n++) begin
      logic e_act, e_dat, e_ov, e_err, e_rdy;
      e_act = (n >= 2) && (n <= act_last);
      e_dat = e_act ? v.word[n - 2] : 1'b0;
      e_ov  = v.ok && (n == v.end_n);
      e_err = !v.ok && (n >= v.end_n);
      e_rdy = v.ok ? (n > v.end_n) : (n >= v.end_n);
      if (e_ov) exp_crc_out = v.crc;
      check(name, n,
            {In_Ready, Eng_RST, Active, Data,
             Out_Valid, Err, CRC_Out},
            {e_rdy, n != 1, e_act, e_dat,
             e_ov, e_err, exp_crc_out});
`ifdef LFSR_CRC_CHECK_EN
      if (n == 1)
        check({name, "_match_clr"}, n, Match, 1'b0);
      if (e_ov)
        check({name, "_match"}, n, Match, v.crc == v.exp);
`endif
      Valid = (n >= v.vstart) && (n < v.vstart + v.vlen);
      if (n >= v.vstart && n - v.vstart < CW)
        CRC = v.crc[n - v.vstart];
      else
        CRC = 1'($urandom_range(0, 1));
      @(posedge CLK);
      @(negedge CLK);
    end
    Valid = 1'b0;
    CRC   = 1'b0;
  endtask

  initial begin
    vec_t r;
    logic [DW-1:0] w;
    logic [CW-1:0] c;
    int m;

    tbl[0] = '{8'hA5, 8'h3C, 8'h3C, 11, 8, 19, 1'b1};
    tbl[1] = '{8'hA5, 8'h3C, 8'h3D, 11, 8, 19, 1'b1};
    tbl[2] = '{8'h5A, 8'h77, 8'h77, 0, 0, 26, 1'b0};
    tbl[3] = '{8'hC3, 8'h12, 8'h12, 11, 3, 15, 1'b0};
    tbl[4] = '{8'h0F, 8'hAA, 8'hAA, 5, 4, 6, 1'b0};
    tbl[5] = '{8'h81, 8'hE7, 8'hE7, 25, 8, 33, 1'b1};
    tbl[6] = '{8'h33, 8'h44, 8'h44, 26, 8, 26, 1'b0};
    tbl[7] = '{8'hF0, 8'h01, 8'h00, 10, 9, 18, 1'b1};

    // reset values
    @(negedge CLK);
    @(negedge CLK);
    check("reset", 0,
          {In_Ready, Eng_RST, Active, Data,
           Out_Valid, Err, CRC_Out},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    RST = 1'b1;
    @(negedge CLK);

    // directed table
    for (int t = 0; t < 8; t++)
      run_frame($sformatf("tbl%0d", t), tbl[t]);

    // In_Valid held high across two frames
    In_Data  = 8'h01;
    In_Valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    In_Data = 8'hFF;
    for (int n = 1; n <= 40; n++) begin
      m = (n <= 20) ? n : n - 20;
      w = (n <= 20) ? 8'h01 : 8'hFF;
      c = (n <= 20) ? 8'h96 : 8'h69;
      if (n == 19 || n == 39) exp_crc_out = c;
      check("b2b", n,
            {In_Ready, Eng_RST, Active, Data,
             Out_Valid, Err, CRC_Out},
            {n == 20 || n == 40, !(n == 1 || n == 21),
             m >= 2 && m <= 9,
             (m >= 2 && m <= 9) ? w[m - 2] : 1'b0,
             n == 19 || n == 39, 1'b0, exp_crc_out});
      if (n == 21) In_Valid = 1'b0;
      Valid = (m >= 11) && (m <= 18);
      CRC   = Valid ? c[m - 11] : 1'b0;
      @(posedge CLK);
      @(negedge CLK);
    end
    Valid = 1'b0;

    // async reset during serial bit 4
    In_Data  = 8'hA5;
    In_Valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    In_Valid = 1'b0;
    for (int n = 1; n < 6; n++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    check("mid_bit4", 6, {Active, Data}, {1'b1, 1'b0});
    #2 RST = 1'b0;
    #1;
    exp_crc_out = '0;
    check("mid_rst", 6,
          {In_Ready, Eng_RST, Active, Data,
           Out_Valid, Err, CRC_Out},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    run_frame("after_rst", tbl[0]);

    // randomized frames against the model
    for (int k = 0; k < 40; k++) begin
      r.word   = DW'($urandom);
      r.crc    = CW'($urandom);
      r.exp    = $urandom_range(0, 1) ? r.crc : CW'($urandom);
      r.vstart = $urandom_range(2, DW + 2 + TO);
      r.vlen   = $urandom_range(0, 3) == 0 ?
                 $urandom_range(0, CW - 1) : CW;
      model(r.vstart, r.vlen, r.end_n, r.ok);
      run_frame($sformatf("rnd%0d", k), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
